// File: rtl/mult4_arb_seq.sv
// Two-requester 4x4 unsigned multiplier sharing one shift-add engine.
// Round-robin arbitration in IDLE, four CALC steps, result held in DONE until consumed.
module mult4_arb_seq #(
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [3:0] req0_a_i,
    input  logic [3:0] req0_b_i,
    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    input  logic [3:0] req1_a_i,
    input  logic [3:0] req1_b_i,
    output logic       res_valid_o,
    input  logic       res_ready_i,
    output logic [7:0] res_o,
    output logic       res_id_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] h_q, h_d;
    logic [3:0] l_q, l_d;
    logic [3:0] b_q, b_d;
    logic [1:0] cnt_q, cnt_d;
    logic       id_q, id_d;
    logic       prio_q, prio_d;

    logic       grant_any;
    logic       grant_id;
    logic [3:0] a_sel;
    logic [3:0] b_sel;

    logic [3:0] addend;
    logic [3:0] sum;
    logic [4:0] carry;

    // prio_q names the requester that wins when both are valid
    assign grant_any = req0_valid_i | req1_valid_i;
    assign grant_id  = (req0_valid_i && req1_valid_i) ? prio_q : req1_valid_i;

    assign req0_ready_o = rst_n && (state_q == S_IDLE) && grant_any && !grant_id;
    assign req1_ready_o = rst_n && (state_q == S_IDLE) && grant_any &&  grant_id;

    assign a_sel = grant_id ? req1_a_i : req0_a_i;
    assign b_sel = grant_id ? req1_b_i : req0_b_i;

    // Ripple-carry adder; a zero addend makes the sum equal H with no carry,
    // so the shift below is correct whether or not L[0] was set.
    assign addend   = b_q & {4{l_q[0]}};
    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_add
            assign sum[gi]     = h_q[gi] ^ addend[gi] ^ carry[gi];
            assign carry[gi+1] = (h_q[gi] & addend[gi]) | (carry[gi] & (h_q[gi] ^ addend[gi]));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        l_d     = l_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        prio_d  = prio_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    id_d   = grant_id;
                    prio_d = ~grant_id;
                    b_d    = b_sel;
                    h_d    = 4'h0;
                    cnt_d  = 2'd0;
                    if (FAST_ZERO && ((a_sel == 4'h0) || (b_sel == 4'h0))) begin
                        l_d     = 4'h0;
                        state_d = S_DONE;
                    end else begin
                        l_d     = a_sel;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                h_d   = {carry[4], sum[3:1]};
                l_d   = {sum[0], l_q[3:1]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            h_q     <= 4'h0;
            l_q     <= 4'h0;
            b_q     <= 4'h0;
            cnt_q   <= 2'd0;
            id_q    <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            l_q     <= l_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
        end
    end

    assign res_valid_o = (state_q == S_DONE);
    assign res_o       = res_valid_o ? {h_q, l_q} : 8'h00;
    assign res_id_o    = res_valid_o & id_q;

endmodule

// File: tb/tb_mult4_arb_seq.sv
// Self-checking bench for mult4_arb_seq: vector table, hand sequences for
// backpressure, arbitration and reset, then an exhaustive randomized run.
module tb_mult4_arb_seq;

    logic       clk;
    logic       rst_n;
    logic       req0_valid_i, req1_valid_i;
    logic       req0_ready_o, req1_ready_o;
    logic [3:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic       res_valid_o, res_ready_i;
    logic [7:0] res_o;
    logic       res_id_o;

    // second instance with the zero bypass disabled
    logic       nz_valid, nz_ready0, nz_ready1, nz_res_valid, nz_res_ready, nz_res_id;
    logic [3:0] nz_a, nz_b;
    logic [7:0] nz_res;
    logic       nz_v1;
    logic [3:0] nz_zero4;

    int total = 0;
    int bad   = 0;

    mult4_arb_seq #(.FAST_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_o(res_o), .res_id_o(res_id_o)
    );

    mult4_arb_seq #(.FAST_ZERO(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(nz_valid), .req0_ready_o(nz_ready0),
        .req0_a_i(nz_a), .req0_b_i(nz_b),
        .req1_valid_i(nz_v1), .req1_ready_o(nz_ready1),
        .req1_a_i(nz_zero4), .req1_b_i(nz_zero4),
        .res_valid_o(nz_res_valid), .res_ready_i(nz_res_ready),
        .res_o(nz_res), .res_id_o(nz_res_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit id, input bit v, input logic [3:0] a, input logic [3:0] b);
        if (id) begin
            req1_valid_i = v; req1_a_i = a; req1_b_i = b;
        end else begin
            req0_valid_i = v; req0_a_i = a; req0_b_i = b;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0; nz_valid = 1'b0;
        res_ready_i = 1'b0; nz_res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Issue one pair and measure edges from transfer to the result handshake edge.
    task automatic do_op(input bit id, input logic [3:0] a, input logic [3:0] b,
                         output logic [7:0] res, output bit rid, output int lat, output bit pulse_ok);
        bit got = 1'b0;
        bit seen = 1'b0;
        int edges = 0;
        res = 8'h00; rid = 1'b0; lat = -1; pulse_ok = 1'b0;
        set_req(id, 1'b1, a, b);
        for (int g = 0; g < 50 && !got; g++) begin
            @(negedge clk);
            got = id ? req1_ready_o : req0_ready_o;
            if (!got) begin
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            check("accept_timeout", 0, 1);
            set_req(id, 1'b0, 4'h0, 4'h0);
            return;
        end
        @(posedge clk); #1;
        set_req(id, 1'b0, 4'h0, 4'h0);
        for (int g = 0; g < 20 && !seen; g++) begin
            @(negedge clk);
            if (res_valid_o) begin
                seen = 1'b1; res = res_o; rid = res_id_o;
            end else begin
                @(posedge clk); edges++;
            end
        end
        if (seen) lat = edges + 1;
        @(posedge clk);
        @(negedge clk);
        pulse_ok = !res_valid_o;
    endtask

    typedef struct {
        bit         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    logic [7:0] r;
    bit         rid, pok;
    int         lat;

    // randomized-phase scoreboard
    logic [7:0] exp0_q[$];
    logic [7:0] exp1_q[$];
    int res0_n, res1_n;

    task automatic drive_port(input int p);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] k;
            logic [3:0] a, b;
            bit got;
            k = (p == 0) ? i[7:0] : 8'(255 - i);
            a = k[7:4]; b = k[3:0];
            got = 1'b0;
            set_req(p[0], 1'b1, a, b);
            for (int g = 0; g < 300 && !got; g++) begin
                @(negedge clk);
                got = (p == 0) ? req0_ready_o : req1_ready_o;
                @(posedge clk); #1;
            end
            if (!got) begin
                check("rand_accept_timeout", p, -1);
            end else if (p == 0) begin
                exp0_q.push_back(8'({4'h0, a} * {4'h0, b}));
            end else begin
                exp1_q.push_back(8'({4'h0, a} * {4'h0, b}));
            end
            set_req(p[0], 1'b0, 4'h0, 4'h0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor_rand();
        bit last_gid = 1'b1;
        for (int c = 0; c < 30000 && (res0_n + res1_n) < 512; c++) begin
            @(posedge clk); #1;
            res_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (req0_ready_o || req1_ready_o) begin
                bit gid = req1_ready_o;
                if (req0_valid_i && req1_valid_i) check("rr_grant", gid, !last_gid);
                last_gid = gid;
            end
            if (res_valid_o && res_ready_i) begin
                logic [7:0] e;
                if (res_id_o == 1'b0) begin
                    if (exp0_q.size() == 0) begin
                        check("rand_dup_id0", 1, 0);
                    end else begin
                        e = exp0_q.pop_front();
                        check("rand_res_id0", res_o, e);
                        res0_n++;
                    end
                end else begin
                    if (exp1_q.size() == 0) begin
                        check("rand_dup_id1", 1, 0);
                    end else begin
                        e = exp1_q.pop_front();
                        check("rand_res_id1", res_o, e);
                        res1_n++;
                    end
                end
            end
        end
    endtask

    initial begin
        int n;
        int bad_hold;
        int pulses;
        int edges;
        bit got, seen;
        logic [7:0] exp_res[4];
        bit         exp_id[4];
        logic [7:0] got_res[4];
        bit         got_id[4];

        vecs[0]  = '{1'b0, 4'hF, 4'hF, 8'hE1, 5};
        vecs[1]  = '{1'b1, 4'hA, 4'hC, 8'h78, 5};
        vecs[2]  = '{1'b0, 4'h0, 4'h9, 8'h00, 1};
        vecs[3]  = '{1'b1, 4'h9, 4'h0, 8'h00, 1};
        vecs[4]  = '{1'b0, 4'h1, 4'h1, 8'h01, 5};
        vecs[5]  = '{1'b1, 4'hF, 4'h1, 8'h0F, 5};
        vecs[6]  = '{1'b0, 4'h8, 4'h8, 8'h40, 5};
        vecs[7]  = '{1'b1, 4'h5, 4'hE, 8'h46, 5};
        vecs[8]  = '{1'b0, 4'h7, 4'h9, 8'h3F, 5};
        vecs[9]  = '{1'b1, 4'h1, 4'hF, 8'h0F, 5};
        vecs[10] = '{1'b0, 4'hC, 4'h3, 8'h24, 5};
        vecs[11] = '{1'b1, 4'h0, 4'h0, 8'h00, 1};

        nz_v1 = 1'b0; nz_zero4 = 4'h0; nz_a = 4'h0; nz_b = 4'h0;
        req0_a_i = 4'h0; req0_b_i = 4'h0; req1_a_i = 4'h0; req1_b_i = 4'h0;
        res0_n = 0; res1_n = 0;

        // reset state, with both valids high to show readies are gated
        rst_n = 1'b0; res_ready_i = 1'b0; nz_res_ready = 1'b0; nz_valid = 1'b0;
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        #3;
        check("rst_res_valid", res_valid_o, 0);
        check("rst_res", res_o, 0);
        check("rst_res_id", res_id_o, 0);
        check("rst_ready0", req0_ready_o, 0);
        check("rst_ready1", req1_ready_o, 0);
        $display("reset: res_valid=%0d res=%02h id=%0d rdy0=%0d rdy1=%0d",
                 res_valid_o, res_o, res_id_o, req0_ready_o, req1_ready_o);
        do_reset();

        // table vectors
        res_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].id, vecs[i].a, vecs[i].b, r, rid, lat, pok);
            $display("vec %0d: id%0d %0h*%0h -> res=%02h id=%0d lat=%0d", i, vecs[i].id,
                     vecs[i].a, vecs[i].b, r, rid, lat);
            check($sformatf("vec%0d_res", i), r, vecs[i].exp);
            check($sformatf("vec%0d_id", i), rid, vecs[i].id);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_pulse", i), pok, 1);
        end

        // round-robin with both requesters continuously valid
        do_reset();
        res_ready_i = 1'b1;
        set_req(1'b0, 1'b1, 4'h3, 4'h5);
        set_req(1'b1, 1'b1, 4'h7, 4'h9);
        exp_res = '{8'h0F, 8'h3F, 8'h0F, 8'h3F};
        exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
        got_res = '{8'h00, 8'h00, 8'h00, 8'h00};
        got_id  = '{1'b0, 1'b0, 1'b0, 1'b0};
        n = 0;
        for (int g = 0; g < 60 && n < 4; g++) begin
            @(negedge clk);
            if (res_valid_o) begin
                got_res[n] = res_o; got_id[n] = res_id_o; n++;
            end
            @(posedge clk); #1;
        end
        set_req(1'b0, 1'b0, 4'h0, 4'h0);
        set_req(1'b1, 1'b0, 4'h0, 4'h0);
        check("rr_count", n, 4);
        for (int i = 0; i < 4; i++) begin
            $display("rr %0d: res=%02h id=%0d", i, got_res[i], got_id[i]);
            check($sformatf("rr%0d_res", i), got_res[i], exp_res[i]);
            check($sformatf("rr%0d_id", i), got_id[i], exp_id[i]);
        end

        // backpressure: result held while res_ready_i low
        do_reset();
        res_ready_i = 1'b0;
        set_req(1'b1, 1'b1, 4'hA, 4'hC);
        got = 1'b0;
        for (int g = 0; g < 20 && !got; g++) begin
            @(negedge clk);
            got = req1_ready_o;
            @(posedge clk); #1;
        end
        check("bp_accept", got, 1);
        set_req(1'b0, 1'b1, 4'h1, 4'h1);
        set_req(1'b1, 1'b1, 4'h2, 4'h2);
        seen = 1'b0;
        for (int g = 0; g < 20 && !seen; g++) begin
            @(negedge clk);
            seen = res_valid_o;
            if (!seen) begin
                @(posedge clk); #1;
            end
        end
        check("bp_seen", seen, 1);
        bad_hold = 0;
        for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            if (!res_valid_o || res_o != 8'h78 || res_id_o != 1'b1 || req0_ready_o || req1_ready_o)
                bad_hold++;
        end
        $display("bp: res=%02h id=%0d held, hold_errors=%0d", res_o, res_id_o, bad_hold);
        check("bp_hold", bad_hold, 0);
        @(posedge clk); #1;
        res_ready_i = 1'b1;
        @(negedge clk);
        check("bp_last_valid", res_valid_o, 1);
        check("bp_last_res", res_o, 8'h78);
        @(posedge clk); #1;
        res_ready_i = 1'b0;
        @(negedge clk);
        check("bp_after_valid", res_valid_o, 0);
        check("bp_after_ready0", req0_ready_o, 1);
        check("bp_after_ready1", req1_ready_o, 0);
        set_req(1'b0, 1'b0, 4'h0, 4'h0);
        set_req(1'b1, 1'b0, 4'h0, 4'h0);

        // zero operand with the bypass disabled takes the full latency
        do_reset();
        nz_res_ready = 1'b1;
        nz_valid = 1'b1; nz_a = 4'h0; nz_b = 4'h9;
        got = 1'b0;
        for (int g = 0; g < 20 && !got; g++) begin
            @(negedge clk);
            got = nz_ready0;
            if (!got) begin
                @(posedge clk); #1;
            end
        end
        check("nz_accept", got, 1);
        @(posedge clk); #1;
        nz_valid = 1'b0;
        seen = 1'b0; edges = 0; r = 8'hFF;
        for (int g = 0; g < 20 && !seen; g++) begin
            @(negedge clk);
            if (nz_res_valid) begin
                seen = 1'b1; r = nz_res;
            end else begin
                @(posedge clk); edges++;
            end
        end
        $display("nz: 0*9 -> res=%02h lat=%0d", r, edges + 1);
        check("nz_seen", seen, 1);
        check("nz_res", r, 8'h00);
        check("nz_lat", edges + 1, 5);

        // reset during CALC step 2 discards the operation
        do_reset();
        res_ready_i = 1'b1;
        set_req(1'b0, 1'b1, 4'h6, 4'h7);
        got = 1'b0;
        for (int g = 0; g < 20 && !got; g++) begin
            @(negedge clk);
            got = req0_ready_o;
            if (!got) begin
                @(posedge clk); #1;
            end
        end
        check("mid_accept", got, 1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 4'h0, 4'h0);
        @(posedge clk);
        @(posedge clk); #1;
        req0_valid_i = 1'b1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", res_valid_o, 0);
        check("mid_rst_res", res_o, 0);
        check("mid_rst_id", res_id_o, 0);
        check("mid_rst_ready0", req0_ready_o, 0);
        check("mid_rst_ready1", req1_ready_o, 0);
        @(posedge clk); #1;
        req0_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int g = 0; g < 8; g++) begin
            @(negedge clk);
            if (res_valid_o) pulses++;
        end
        check("mid_no_pulse", pulses, 0);
        do_op(1'b0, 4'h2, 4'h3, r, rid, lat, pok);
        $display("post-reset: 2*3 -> res=%02h id=%0d lat=%0d", r, rid, lat);
        check("post_res", r, 8'h06);
        check("post_id", rid, 0);
        check("post_lat", lat, 5);

        // exhaustive randomized run on both ports with random backpressure
        do_reset();
        fork
            drive_port(0);
            drive_port(1);
            monitor_rand();
        join
        res_ready_i = 1'b0;
        $display("random: id0 results=%0d id1 results=%0d left0=%0d left1=%0d",
                 res0_n, res1_n, exp0_q.size(), exp1_q.size());
        check("rand_count0", res0_n, 256);
        check("rand_count1", res1_n, 256);
        check("rand_left0", exp0_q.size(), 0);
        check("rand_left1", exp1_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
